// File: rtl/usb_crc_rx_check.sv
// Receive-side CRC16 checker for USB DATA packets: skips the PID byte, runs the
// USB CRC16 over data plus received CRC, and reports the end-of-packet verdict.
module usb_crc_rx_check #(
    parameter int          CNT_W    = 11,
    parameter logic [15:0] RESIDUAL = 16'h800D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_sop,
    input  logic             rx_bit,
    input  logic             rx_shift,
    input  logic             rx_hold,
    input  logic             rx_eop,
    output logic [15:0]      crc_16,
    output logic             crc_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             align_err,
    output logic             short_err,
    output logic [CNT_W-1:0] data_bytes,
    output logic [1:0]       fsm_state
);

    // Strobe semantics: rx_sop/rx_eop are single-cycle events with no backpressure;
    // a bit is consumed only when rx_shift=1 and rx_hold=0 in the same cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PID  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [15:0]      crc_q;
    logic [2:0]       bit_cnt;
    logic [2:0]       pid_cnt;
    logic [CNT_W-1:0] byte_cnt;

    logic             acc;
    logic             fb;
    logic [15:0]      crc_upd;
    logic [2:0]       bit_cnt_upd;
    logic [CNT_W-1:0] byte_cnt_upd;
    logic [15:0]      crc_eval;
    logic [2:0]       bit_eval;
    logic [CNT_W-1:0] byte_eval;
    logic             eval_align;
    logic             eval_short;
    logic             eval_ok;

    always_comb begin
        acc          = rx_shift && !rx_hold;
        fb           = rx_bit ^ crc_q[15];
        crc_upd      = {crc_q[14] ^ fb, crc_q[13:2], crc_q[1] ^ fb, crc_q[0], fb};
        bit_cnt_upd  = bit_cnt + 3'd1;
        byte_cnt_upd = byte_cnt;
        if (bit_cnt == 3'd7 && byte_cnt != {CNT_W{1'b1}}) begin
            byte_cnt_upd = byte_cnt + CNT_W'(1);
        end
        // A bit arriving with rx_eop is absorbed before the verdict is taken
        crc_eval   = acc ? crc_upd : crc_q;
        bit_eval   = acc ? bit_cnt_upd : bit_cnt;
        byte_eval  = acc ? byte_cnt_upd : byte_cnt;
        eval_align = (bit_eval != 3'd0);
        eval_short = (byte_eval < CNT_W'(2));
        eval_ok    = (crc_eval == RESIDUAL) && !eval_align && !eval_short;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            crc_q      <= 16'hFFFF;
            bit_cnt    <= 3'd0;
            pid_cnt    <= 3'd0;
            byte_cnt   <= '0;
            crc_done   <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            align_err  <= 1'b0;
            short_err  <= 1'b0;
            data_bytes <= '0;
        end else if (rx_sop) begin
            state      <= PID;
            crc_q      <= 16'hFFFF;
            bit_cnt    <= 3'd0;
            pid_cnt    <= 3'd0;
            byte_cnt   <= '0;
            crc_done   <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            align_err  <= 1'b0;
            short_err  <= 1'b0;
            data_bytes <= '0;
        end else begin
            crc_done <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                PID: begin
                    if (rx_eop) begin
                        state      <= DONE;
                        crc_done   <= 1'b1;
                        crc_ok     <= 1'b0;
                        crc_err    <= 1'b1;
                        align_err  <= 1'b0;
                        short_err  <= 1'b1;
                        data_bytes <= '0;
                    end else if (acc) begin
                        pid_cnt <= pid_cnt + 3'd1;
                        if (pid_cnt == 3'd7) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (acc) begin
                        crc_q    <= crc_upd;
                        bit_cnt  <= bit_cnt_upd;
                        byte_cnt <= byte_cnt_upd;
                    end
                    if (rx_eop) begin
                        state      <= DONE;
                        crc_done   <= 1'b1;
                        crc_ok     <= eval_ok;
                        crc_err    <= !eval_ok;
                        align_err  <= eval_align;
                        short_err  <= eval_short;
                        data_bytes <= eval_short ? '0 : byte_eval - CNT_W'(2);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign crc_16    = crc_q;
    assign fsm_state = state;

endmodule
